// File: rtl/io_controller_if.sv
// CPU-side bus of the I/O controller: command/write data in, captured input and stall out.
// The CPU drives the master side; the controller drives the slave side.
interface io_controller_if;
    logic [1:0]  control;
    logic [31:0] MemOut;
    logic [31:0] IData;
    logic        io_wait;

    modport master (output control, output MemOut, input IData, input io_wait);
    modport slave  (input control, input MemOut, output IData, output io_wait);
endinterface

// File: rtl/io_controller.sv
// Memory-mapped I/O controller: LED/display write registers, debounced enter button and a
// blocking switch-input request. Optional macro IO_BLANK_LEADING_ZEROS_EN blanks leading zero digits.
module io_controller #(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int DIGITS          = 8,
    parameter int FLAG_WIDTH      = 5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    io_controller_if.slave        bus,
    input  logic                  enter,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic [FLAG_WIDTH-1:0] flags,
    output logic [LED_WIDTH-1:0]  RedLEDs,
    output logic [FLAG_WIDTH-1:0] GreenLEDs,
    output logic [7*DIGITS-1:0]   SevenSegDisplays
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

    state_t               state_reg, state_next;
    logic                 capture;
    logic [LED_WIDTH-1:0] led_reg;
    logic [31:0]          disp_reg;
    logic [31:0]          idata_reg;
    logic                 enter_s1_reg, enter_s2_reg, enter_db_reg;
    logic [CNT_W-1:0]     db_cnt_reg;
    logic [SW_WIDTH-1:0]  sw_s1_reg, sw_s2_reg;
    logic [31:0]          sw_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_s1_reg <= 1'b0;
            enter_s2_reg <= 1'b0;
            sw_s1_reg    <= '0;
            sw_s2_reg    <= '0;
        end else begin
            enter_s1_reg <= enter;
            enter_s2_reg <= enter_s1_reg;
            sw_s1_reg    <= switches;
            sw_s2_reg    <= sw_s1_reg;
        end
    end

    // Accept a new button level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_db_reg <= 1'b0;
            db_cnt_reg   <= '0;
        end else if (enter_s2_reg != enter_db_reg) begin
            if (db_cnt_reg == CNT_LAST) begin
                enter_db_reg <= enter_s2_reg;
                db_cnt_reg   <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end else begin
            db_cnt_reg <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE:         if (bus.control == 2'd3) state_next = WAIT_PRESS;
            WAIT_PRESS: begin
                if (bus.control != 2'd3) begin
                    state_next = IDLE;
                end else if (enter_db_reg) begin
                    capture    = 1'b1;
                    state_next = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (bus.control != 2'd3)  state_next = IDLE;
                else if (!enter_db_reg)   state_next = DONE;
            end
            default:      state_next = IDLE;
        endcase
    end

    always_comb begin
        sw_ext                 = '0;
        sw_ext[SW_WIDTH-1:0]   = sw_s2_reg;
    end

    // Register writes only land while idle; the CPU cannot issue them while stalled anyway.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_reg   <= '0;
            disp_reg  <= '0;
            idata_reg <= '0;
        end else begin
            if (bus.control == 2'd1 && state_reg == IDLE) led_reg  <= bus.MemOut[LED_WIDTH-1:0];
            if (bus.control == 2'd2 && state_reg == IDLE) disp_reg <= bus.MemOut;
            if (capture) idata_reg <= sw_ext;
        end
    end

    assign RedLEDs     = led_reg;
    assign GreenLEDs   = flags;
    assign bus.IData   = idata_reg;
    // Reset gates the stall so a mid-request reset releases the CPU immediately.
    assign bus.io_wait = !reset && (bus.control == 2'd3) && (state_reg != DONE);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

`ifdef IO_BLANK_LEADING_ZEROS_EN
    // upper_zero[i]: nibble i and every nibble above it are zero.
    logic [DIGITS:0] upper_zero;
    assign upper_zero[DIGITS] = 1'b1;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = disp_reg[4*gi +: 4];
`ifdef IO_BLANK_LEADING_ZEROS_EN
            assign upper_zero[gi] = (nib == 4'h0) && upper_zero[gi+1];
            assign SevenSegDisplays[7*gi +: 7] =
                (gi != 0 && upper_zero[gi]) ? 7'h7F : hex_to_seg(nib);
`else
            assign SevenSegDisplays[7*gi +: 7] = hex_to_seg(nib);
`endif
        end
    endgenerate
endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: directed steps then random requests/writes,
// compared every cycle against a behavioural model of the controller's registers.
module tb_io_controller;
    localparam int DEB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        enter;
    logic [15:0] switches;
    logic [4:0]  flags;
    logic [15:0] RedLEDs;
    logic [4:0]  GreenLEDs;
    logic [55:0] SevenSegDisplays;

    io_controller_if bus();

    io_controller #(
        .SW_WIDTH(16), .LED_WIDTH(16), .DIGITS(8), .FLAG_WIDTH(5), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .enter(enter), .switches(switches),
        .flags(flags), .RedLEDs(RedLEDs), .GreenLEDs(GreenLEDs),
        .SevenSegDisplays(SevenSegDisplays)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Lit-segment font (1 = lit, bit0 = a ... bit6 = g).
    logic [6:0] font [16];

    // Model state
    logic        m_s1, m_s2, m_db;
    logic [15:0] m_sw1, m_sw2;
    int          m_run;
    int          m_phase; // 0 idle, 1 awaiting press, 2 awaiting release, 3 done
    logic [15:0] m_led;
    logic [31:0] m_disp, m_idata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] seg_model(input logic [31:0] v);
        logic [55:0] r;
        int top;
        top = 0;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) top = i;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[7*i +: 7] = ~font[v[4*i +: 4]];
`ifdef IO_BLANK_LEADING_ZEROS_EN
            if (i > top) r[7*i +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_sw1 = 0; m_sw2 = 0; m_run = 0;
        m_phase = 0; m_led = 0; m_disp = 0; m_idata = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        logic o_s2, o_db;
        logic [15:0] o_sw2;
        int o_ph;
        o_s2 = m_s2; o_db = m_db; o_sw2 = m_sw2; o_ph = m_phase;
        m_s2 = m_s1; m_s1 = enter; m_sw2 = m_sw1; m_sw1 = switches;
        if (o_s2 != o_db) begin
            m_run++;
            if (m_run == DEB) begin m_db = o_s2; m_run = 0; end
        end else m_run = 0;
        if (o_ph == 0 && bus.control == 2'd1) m_led = bus.MemOut[15:0];
        if (o_ph == 0 && bus.control == 2'd2) m_disp = bus.MemOut;
        case (o_ph)
            0: if (bus.control == 2'd3) m_phase = 1;
            1: if (bus.control != 2'd3) m_phase = 0;
               else if (o_db) begin m_idata = {16'h0, o_sw2}; m_phase = 2; end
            2: if (bus.control != 2'd3) m_phase = 0;
               else if (!o_db) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_all();
        logic exp_wait;
        exp_wait = !reset && bus.control == 2'd3 && m_phase != 3;
        chk("RedLEDs", 64'(RedLEDs), 64'(m_led));
        chk("display", 64'(SevenSegDisplays), 64'(seg_model(m_disp)));
        chk("IData", 64'(bus.IData), 64'(m_idata));
        chk("io_wait", 64'(bus.io_wait), 64'(exp_wait));
        chk("GreenLEDs", 64'(GreenLEDs), 64'(flags));
    endtask

    task automatic edge_step();
        @(posedge clock);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_all();
            edge_step();
        end
    endtask

    // Hold control=3 until io_wait drops, keep it one more cycle, then let the CPU advance.
    task automatic run_request(input int budget, output int zero_cycles);
        int after;
        zero_cycles = 0;
        after = -1;
        for (int i = 0; i < budget && after != 0; i++) begin
            @(negedge clock);
            check_all();
            if (bus.control == 2'd3 && bus.io_wait === 1'b0) zero_cycles++;
            if (after > 0) after--;
            if (after < 0 && bus.io_wait === 1'b0) after = 1;
            if (after == 0) bus.control = 2'd0;
            edge_step();
        end
        if (after != 0) begin
            bus.control = 2'd0;
            chk("request_timeout", 64'(after), 64'd0);
        end
    endtask

    int zc;
    int seg_left;
    logic lvl;

    initial begin
        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        reset = 1; enter = 0; switches = 0; flags = 0;
        bus.control = 0; bus.MemOut = 0;
        model_reset();
        #3;
        check_all();
        @(negedge clock);
        reset = 0;
        edge_step();

        // LED write, then asynchronous reset clears it without a clock edge
        bus.control = 2'd1; bus.MemOut = 32'h0000_A5A5;
        tick(1);
        bus.control = 2'd0;
        @(negedge clock);
        chk("led_a5a5", 64'(RedLEDs), 64'h A5A5);
        edge_step();
        #2 reset = 1; model_reset();
        #1 chk("led_async_reset", 64'(RedLEDs), 64'h0);
        check_all();
        #1 reset = 0;
        edge_step();

        // Display write
        bus.control = 2'd2; bus.MemOut = 32'h0123_4567;
        tick(1);
        bus.control = 2'd0;
        @(negedge clock);
        chk("digit0", 64'(SevenSegDisplays[6:0]), 64'h78);
`ifdef IO_BLANK_LEADING_ZEROS_EN
        chk("digit7", 64'(SevenSegDisplays[55:49]), 64'h7F);
        chk("digit6", 64'(SevenSegDisplays[48:42]), 64'h79);
`else
        chk("digit7", 64'(SevenSegDisplays[55:49]), 64'h40);
`endif
        edge_step();

        // Short glitch rejected, long press captured
        switches = 16'h00FF; bus.control = 2'd3;
        tick(4);
        enter = 1; tick(3);
        enter = 0; tick(10);
        @(negedge clock);
        chk("glitch_wait", 64'(bus.io_wait), 64'h1);
        edge_step();
        enter = 1; tick(8);
        enter = 0;
        run_request(40, zc);
        chk("done_one_cycle", 64'(zc), 64'd1);
        chk("idata_ff", 64'(bus.IData), 64'h0000_00FF);
        tick(2);

        // Abort before any press
        switches = 16'h5555; bus.control = 2'd3;
        tick(3);
        bus.control = 2'd0;
        tick(1);
        @(negedge clock);
        chk("abort_wait", 64'(bus.io_wait), 64'h0);
        chk("abort_idata", 64'(bus.IData), 64'h0000_00FF);
        edge_step();

        // Button already held when the request starts
        enter = 1; switches = 16'h1234;
        tick(10);
        bus.control = 2'd3;
        tick(2);
        @(negedge clock);
        chk("held_capture", 64'(bus.IData), 64'h0000_1234);
        chk("held_wait", 64'(bus.io_wait), 64'h1);
        edge_step();
        enter = 0;
        run_request(40, zc);
        chk("held_done_one_cycle", 64'(zc), 64'd1);

        // Flags passthrough in the same cycle
        flags = 5'b10101;
        #1 chk("flags", 64'(GreenLEDs), 64'b10101);
        tick(1);

        // Reset mid-request releases the stall at once
        bus.control = 2'd3;
        tick(3);
        #2 reset = 1; model_reset();
        #1 chk("reset_mid_wait", 64'(bus.io_wait), 64'h0);
        check_all();
        bus.control = 2'd0;
        #1 reset = 0;
        edge_step();
        tick(2);

        // Random writes and requests
        lvl = 0;
        for (int op = 0; op < 40; op++) begin
            flags = 5'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    bus.control = 2'd1; bus.MemOut = $urandom;
                    tick(1);
                end
                1: begin
                    bus.control = 2'd2;
                    bus.MemOut = $urandom >> ($urandom_range(0, 7) * 4);
                    tick(1);
                end
                default: begin
                    bus.control = 2'd3;
                    switches = 16'($urandom);
                    seg_left = 0;
                    for (int c = 0; c < 80 && bus.control == 2'd3; c++) begin
                        @(negedge clock);
                        check_all();
                        if (bus.io_wait === 1'b0) bus.control = 2'd0;
                        else if ($urandom_range(0, 59) == 0) bus.control = 2'd0;
                        if (seg_left == 0) begin
                            lvl = ~lvl;
                            seg_left = $urandom_range(1, 9);
                        end
                        seg_left--;
                        enter = lvl;
                        if ($urandom_range(0, 7) == 0) switches = 16'($urandom);
                        edge_step();
                    end
                    bus.control = 2'd0;
                end
            endcase
            bus.control = 2'd0;
            tick($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
